// File: rtl/gmii_fifo_read_start_pkg.sv
// Shared definitions for the GMII passthrough read side: FIFO word layout and FSM states.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package gmii_fifo_read_start_pkg;

  // Read-side sequencer states
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

  // FIFO word is {rx_en, rx_er, rxd}; enable sits above error, both above data
  function automatic int en_bit(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int er_bit(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/gmii_fifo_read_start_if.sv
// Bundle of the FIFO read port and GMII TX side (plus event counters) of the read stage.
// Latency: n/a (wiring only).
// Backpressure: the stage is the master of fifo_rdreq; GMII TX has no backpressure.
interface gmii_fifo_read_start_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int USEDW_WIDTH = 8
);
  logic [DATA_WIDTH+1:0]  fifo_q;
  logic                   fifo_rdempty;
  logic [USEDW_WIDTH-1:0] fifo_rdusedw;
  logic                   fifo_rdreq;
  logic                   gmii_tx_en;
  logic                   gmii_tx_er;
  logic [DATA_WIDTH-1:0]  gmii_txd;
  logic [15:0]            underrun_cnt;
  logic [15:0]            frame_cnt;

  // Read stage view
  modport slave (
    input  fifo_q, fifo_rdempty, fifo_rdusedw,
    output fifo_rdreq, gmii_tx_en, gmii_tx_er, gmii_txd, underrun_cnt, frame_cnt
  );

  // Environment view: FIFO side drives data/levels, observes the GMII side
  modport master (
    output fifo_q, fifo_rdempty, fifo_rdusedw,
    input  fifo_rdreq, gmii_tx_en, gmii_tx_er, gmii_txd, underrun_cnt, frame_cnt
  );
endinterface

// File: rtl/gmii_fifo_read_start_sat_counter.sv
// Event counter: saturates at all-ones when SATURATE=1, otherwise wraps.
// Latency: count_o reflects inc_i one clk after it is sampled.
// Backpressure: none; every inc_i pulse is counted (unless saturated).
module gmii_fifo_read_start_sat_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic             at_max;

  assign at_max  = &count_q;
  assign count_o = count_q;

  // Count events; hold at all-ones only in saturating mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc_i && !(SATURATE && at_max)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/gmii_fifo_read_start.sv
// Prefills the RX->TX dual-clock FIFO, unpacks words onto GMII TX, stretches gaps, flags underruns.
// Latency: 2 clk from fifo_rdreq to GMII output (FIFO read cycle + output register).
// Backpressure: stops reading when the FIFO runs low in a gap or empties; GMII has no backpressure.
module gmii_fifo_read_start
  import gmii_fifo_read_start_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int USEDW_WIDTH = 8,
  parameter int START_LEVEL = 4,
  parameter int LOW_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gmii_fifo_read_start_if.slave fifo_gmii
);

  localparam int EN_BIT = en_bit(DATA_WIDTH);

  state_e                state_q;
  logic                  rd_valid_q;
  logic                  in_frame_q;
  logic                  drop_q;
  logic                  err_pend_q;
  logic [DATA_WIDTH+1:0] tx_word_q;
  logic [DATA_WIDTH+1:0] tx_word_d;

  logic word_en;
  logic in_frame;
  logic gap_low;
  logic start_ok;
  logic underrun_det;
  logic rdreq;
  logic frame_start;

  // The word on fifo_q is only meaningful the cycle after a read request
  assign word_en  = fifo_gmii.fifo_q[EN_BIT];
  // Include the word being presented now so a frame's first word counts as in-frame
  assign in_frame = rd_valid_q ? word_en : in_frame_q;
  assign gap_low  = rd_valid_q && !word_en &&
                    (fifo_gmii.fifo_rdusedw < USEDW_WIDTH'(LOW_LEVEL));
  assign start_ok = fifo_gmii.fifo_rdusedw >= USEDW_WIDTH'(START_LEVEL);

  // Emptying mid-frame is an underrun; while already discarding a truncated
  // frame a second empty is not reported again (that frame is already flagged)
  assign underrun_det = (state_q == RUN) && !gap_low && fifo_gmii.fifo_rdempty &&
                        in_frame && !drop_q;

  assign rdreq = (state_q == RUN) && !fifo_gmii.fifo_rdempty && !gap_low;

  // Error marker wins; otherwise forward the read word unless discarding
  assign tx_word_d = err_pend_q             ? {1'b1, 1'b1, {DATA_WIDTH{1'b0}}} :
                     (rd_valid_q && !drop_q) ? fifo_gmii.fifo_q :
                                               '0;

  assign frame_start = tx_word_d[EN_BIT] && !tx_word_q[EN_BIT];

  assign fifo_gmii.fifo_rdreq = rdreq;
  assign fifo_gmii.gmii_tx_en = tx_word_q[EN_BIT];
  assign fifo_gmii.gmii_tx_er = tx_word_q[DATA_WIDTH];
  assign fifo_gmii.gmii_txd   = tx_word_q[DATA_WIDTH-1:0];

  // Sequencer, read tracking, drop mode and the registered GMII output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      rd_valid_q <= 1'b0;
      in_frame_q <= 1'b0;
      drop_q     <= 1'b0;
      err_pend_q <= 1'b0;
      tx_word_q  <= '0;
    end else begin
      rd_valid_q <= rdreq;
      err_pend_q <= underrun_det;
      tx_word_q  <= tx_word_d;

      if (rd_valid_q) begin
        in_frame_q <= word_en;
      end

      // Discard the rest of a truncated frame up to its first idle word
      if (underrun_det) begin
        drop_q <= 1'b1;
      end else if (rd_valid_q && !word_en) begin
        drop_q <= 1'b0;
      end

      case (state_q)
        FILL: begin
          if (start_ok) state_q <= RUN;
        end
        RUN: begin
          if (gap_low) begin
            state_q <= STALL;
          end else if (fifo_gmii.fifo_rdempty) begin
            state_q <= FILL;
          end
        end
        STALL: begin
          if (start_ok) state_q <= RUN;
        end
        default: state_q <= FILL;
      endcase
    end
  end

  gmii_fifo_read_start_sat_counter #(
    .WIDTH    (16),
    .SATURATE (1'b1)
  ) u_underrun_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (underrun_det),
    .count_o (fifo_gmii.underrun_cnt)
  );

  gmii_fifo_read_start_sat_counter #(
    .WIDTH    (16),
    .SATURATE (1'b0)
  ) u_frame_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (frame_start),
    .count_o (fifo_gmii.frame_cnt)
  );

endmodule

// File: tb/tb_gmii_fifo_read_start.sv
// Self-checking bench for gmii_fifo_read_start: FIFO model, vector table and directed sequences.
// Latency: n/a.
// Backpressure: the FIFO model honours fifo_rdreq with normal-mode (next-cycle) read data.
module tb_gmii_fifo_read_start;

  localparam int DW = 8;
  localparam int UW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gmii_fifo_read_start_if #(.DATA_WIDTH(DW), .USEDW_WIDTH(UW)) bus ();

  gmii_fifo_read_start #(
    .DATA_WIDTH  (DW),
    .USEDW_WIDTH (UW),
    .START_LEVEL (4),
    .LOW_LEVEL   (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_gmii (bus)
  );

  // Standalone narrow counters for saturation / wrap behaviour
  logic       sc_rst_n = 1'b0;
  logic       sc_inc   = 1'b0;
  logic [7:0] sat_cnt;
  logic [7:0] wrap_cnt;

  gmii_fifo_read_start_sat_counter #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(sc_rst_n), .inc_i(sc_inc), .count_o(sat_cnt));
  gmii_fifo_read_start_sat_counter #(.WIDTH(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(sc_rst_n), .inc_i(sc_inc), .count_o(wrap_cnt));

  // ---------------- FIFO model (normal mode, same clock both sides) ----------------
  logic [9:0] fq[$];
  logic       wr_en  = 1'b0;
  logic [9:0] wr_dat = '0;
  logic       flush  = 1'b1;
  logic [9:0] pop_w;

  always @(posedge clk) begin
    if (flush) begin
      fq.delete();
    end else begin
      if (bus.fifo_rdreq && fq.size() > 0) begin
        pop_w = fq.pop_front();
        bus.fifo_q <= pop_w;
      end
      if (wr_en) fq.push_back(wr_dat);
    end
    bus.fifo_rdusedw <= UW'(fq.size());
    bus.fifo_rdempty <= (fq.size() == 0);
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       wr_en;
    logic [9:0] wr_dat;
    logic       exp_rdreq;
    logic [9:0] exp_out;   // {en, er, txd}
    logic [15:0] exp_fc;
  } vec_t;

  vec_t tbl[16];

  logic [9:0] wq[$];     // words to write, one per cycle
  logic [9:0] cap[$];    // captured GMII output per cycle
  logic [9:0] expw[$];   // expected enabled GMII words
  int stall_cnt = 0;
  int bad_stall = 0;
  int exp_fc    = 0;

  function automatic logic [9:0] gmii_word();
    return {bus.gmii_tx_en, bus.gmii_tx_er, bus.gmii_txd};
  endfunction

  // One call = n cycles: sample at negedge, then drive the next write
  task automatic run_cycles(input int n, input int bubble_every);
    logic prev_rdreq = 1'b0;
    for (int c = 0; c < n; c++) begin
      cap.push_back(gmii_word());
      if (prev_rdreq && !bus.fifo_rdreq && !bus.fifo_rdempty) begin
        stall_cnt++;
        if (bus.fifo_q[9] || bus.fifo_rdusedw >= UW'(2)) bad_stall++;
      end
      prev_rdreq = bus.fifo_rdreq;
      if (wq.size() > 0 && !(bubble_every > 0 && (c % bubble_every) == bubble_every - 1)) begin
        wr_en  = 1'b1;
        wr_dat = wq.pop_front();
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  // Compare captured enabled words and frame (en-run) count against expectation
  task automatic check_stream(input string name, input int exp_runs);
    logic [9:0] got[$];
    int   runs = 0;
    int   bad  = 0;
    int   first_bad = -1;
    logic prev = 1'b0;
    foreach (cap[i]) begin
      if (cap[i][9]) begin
        got.push_back(cap[i]);
        if (!prev) runs++;
      end
      prev = cap[i][9];
    end
    check({name, "_word_count"}, got.size(), expw.size());
    for (int i = 0; i < got.size() && i < expw.size(); i++) begin
      if (got[i] !== expw[i]) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
    end
    check($sformatf("%s_bad_words(first_at_%0d)", name, first_bad), bad, 0);
    check({name, "_frames"}, runs, exp_runs);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   found;
    // ---------------- vector table: prefill, first frame, gap stall ----------------
    tbl[0]  = '{1'b1, 10'h000, 1'b0, 10'h000, 16'd0};
    tbl[1]  = '{1'b1, 10'h000, 1'b0, 10'h000, 16'd0};
    tbl[2]  = '{1'b1, 10'h000, 1'b0, 10'h000, 16'd0};
    tbl[3]  = '{1'b1, 10'h200, 1'b0, 10'h000, 16'd0};
    tbl[4]  = '{1'b1, 10'h201, 1'b0, 10'h000, 16'd0};
    tbl[5]  = '{1'b1, 10'h202, 1'b1, 10'h000, 16'd0};
    tbl[6]  = '{1'b1, 10'h000, 1'b1, 10'h000, 16'd0};
    tbl[7]  = '{1'b1, 10'h000, 1'b1, 10'h000, 16'd0};
    tbl[8]  = '{1'b1, 10'h000, 1'b1, 10'h000, 16'd0};
    tbl[9]  = '{1'b1, 10'h000, 1'b1, 10'h000, 16'd0};
    tbl[10] = '{1'b0, 10'h000, 1'b1, 10'h200, 16'd1};
    tbl[11] = '{1'b0, 10'h000, 1'b1, 10'h201, 16'd1};
    tbl[12] = '{1'b0, 10'h000, 1'b1, 10'h202, 16'd1};
    tbl[13] = '{1'b0, 10'h000, 1'b1, 10'h000, 16'd1};
    tbl[14] = '{1'b0, 10'h000, 1'b0, 10'h000, 16'd1};
    tbl[15] = '{1'b0, 10'h000, 1'b0, 10'h000, 16'd1};

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("reset_rdreq", bus.fifo_rdreq, 0);
    check("reset_tx_en", bus.gmii_tx_en, 0);
    check("reset_tx_er", bus.gmii_tx_er, 0);
    check("reset_txd", bus.gmii_txd, 0);
    check("reset_frame_cnt", bus.frame_cnt, 0);
    check("reset_underrun_cnt", bus.underrun_cnt, 0);
    check("reset_sat_cnt", sat_cnt, 0);
    rst_n = 1'b1;
    flush = 1'b0;

    for (int k = 0; k < 16; k++) begin
      check($sformatf("vec%0d_{rdreq,en,er,txd,fc}", k),
            {bus.fifo_rdreq, gmii_word(), bus.frame_cnt},
            {tbl[k].exp_rdreq, tbl[k].exp_out, tbl[k].exp_fc});
      wr_en  = tbl[k].wr_en;
      wr_dat = tbl[k].wr_dat;
      @(negedge clk);
    end
    wr_en  = 1'b0;
    exp_fc = 1;

    // ---------------- passthrough: 64-byte frame ----------------
    cap.delete(); expw.delete();
    for (int i = 0; i < 64; i++) begin
      wq.push_back(10'h200 | 10'(i));
      expw.push_back(10'h200 | 10'(i));
    end
    repeat (8) wq.push_back(10'h000);
    run_cycles(100, 0);
    exp_fc++;
    check_stream("pass64", 1);
    check("pass64_frame_cnt", bus.frame_cnt, exp_fc);
    check("pass64_underrun_cnt", bus.underrun_cnt, 0);

    // ---------------- gap stretch: slower writer, 12-idle gaps ----------------
    cap.delete(); expw.delete();
    stall_cnt = 0; bad_stall = 0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 24; i++) begin
        wq.push_back(10'h200 | 10'((f * 24 + i + 8'h40) & 8'hFF));
        expw.push_back(10'h200 | 10'((f * 24 + i + 8'h40) & 8'hFF));
      end
      repeat (12) wq.push_back(10'h000);
    end
    run_cycles(170, 25);
    exp_fc += 3;
    check_stream("gap", 3);
    check("gap_bad_stalls", bad_stall, 0);
    check("gap_stall_seen", (stall_cnt > 0), 1);
    check("gap_frame_cnt", bus.frame_cnt, exp_fc);
    check("gap_underrun_cnt", bus.underrun_cnt, 0);

    // ---------------- underrun after byte 20, then drop and recover ----------------
    cap.delete(); expw.delete();
    for (int i = 0; i <= 20; i++) begin
      wq.push_back(10'h200 | 10'(i));
      expw.push_back(10'h200 | 10'(i));
    end
    expw.push_back(10'h300);
    run_cycles(40, 0);
    check("underrun_cnt_after_trunc", bus.underrun_cnt, 1);
    for (int i = 21; i < 30; i++) wq.push_back(10'h200 | 10'(i));
    repeat (4) wq.push_back(10'h000);
    for (int i = 0; i < 10; i++) begin
      wq.push_back(10'h280 + 10'(i));
      expw.push_back(10'h280 + 10'(i));
    end
    repeat (8) wq.push_back(10'h000);
    run_cycles(60, 0);
    exp_fc += 2;
    check_stream("underrun", 2);
    check("underrun_frame_cnt", bus.frame_cnt, exp_fc);
    check("underrun_cnt_final", bus.underrun_cnt, 1);

    // ---------------- reset while byte 10 is on the wire ----------------
    for (int i = 0; i < 20; i++) wq.push_back(10'h200 | 10'(i));
    repeat (4) wq.push_back(10'h000);
    found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      if (bus.gmii_tx_en && bus.gmii_txd == 8'h0A) begin
        found = 1;
      end else begin
        if (wq.size() > 0) begin
          wr_en = 1'b1; wr_dat = wq.pop_front();
        end else begin
          wr_en = 1'b0;
        end
        @(negedge clk);
      end
    end
    check("midframe_byte10_seen", found, 1);
    rst_n = 1'b0;
    wr_en = 1'b0;
    flush = 1'b1;
    wq.delete();
    #1;
    check("midreset_outputs", {bus.fifo_rdreq, gmii_word()}, 0);
    check("midreset_frame_cnt", bus.frame_cnt, 0);
    check("midreset_underrun_cnt", bus.underrun_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("post_reset_rdreq_usedw%0d", i), bus.fifo_rdreq, 0);
      wr_en = 1'b1; wr_dat = 10'h000;
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("post_reset_rdreq_fill_at4", bus.fifo_rdreq, 0);
    @(negedge clk);
    check("post_reset_rdreq_run", bus.fifo_rdreq, 1);
    repeat (6) @(negedge clk);
    check("post_reset_quiet_out", gmii_word(), 0);

    // ---------------- counter saturation / wrap ----------------
    sc_rst_n = 1'b1;
    sc_inc   = 1'b1;
    repeat (255) @(negedge clk);
    check("sat_at_max", sat_cnt, 8'hFF);
    check("wrap_at_max", wrap_cnt, 8'hFF);
    repeat (45) @(negedge clk);
    check("sat_holds", sat_cnt, 8'hFF);
    check("wrap_rolled", wrap_cnt, 8'd44);
    sc_inc = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_idle_hold", sat_cnt, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
